// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store at a time, strobes held WAIT_CYCLES, result through a valid/ready response.
// Latency: resp_valid WAIT_CYCLES+1 cycles after accept (1 cycle for a trapped misaligned word when LSU_MISALIGN_TRAP_EN is defined).
// Backpressure: req_ready only in IDLE; the response is held until resp_ready, then the next request can be taken.
module load_store_unit #(
  parameter int ADDR_W      = 18,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_byte,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_write_data,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_byte_ops,
  input  logic [31:0]       mem_read_data
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        op_write, op_byte, op_signed;
  logic        accept, capture, misalign;
  logic [31:0] load_data;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    misalign  = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept    = 1'b1;
          state_nxt = ACCESS;
`ifdef LSU_MISALIGN_TRAP_EN
          if (!req_byte && (req_addr[1:0] != 2'b00)) begin
            misalign  = 1'b1;
            state_nxt = RESP;
          end
`endif
        end
      end
      ACCESS: begin
        if (cnt == 4'd0) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);

  always_comb begin
    load_data = mem_read_data;
    if (op_byte) load_data = {{24{op_signed & mem_read_data[7]}}, mem_read_data[7:0]};
    if (op_write) load_data = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      op_write       <= 1'b0;
      op_byte        <= 1'b0;
      op_signed      <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_byte_ops   <= 1'b0;
      resp_rdata     <= '0;
    end else begin
      state <= state_nxt;
      // Address/data only move on a real access, so they are stable while a strobe is high.
      if (accept && !misalign) begin
        mem_address    <= req_addr;
        mem_write_data <= req_wdata;
        op_write       <= req_write;
        op_byte        <= req_byte;
        op_signed      <= req_signed;
        cnt            <= CNT_INIT;
        mem_read       <= !req_write;
        mem_write      <= req_write;
        mem_byte_ops   <= req_byte;
      end
      if (accept && misalign) resp_rdata <= '0;
      if (state == ACCESS) cnt <= cnt - 4'd1;
      if (capture) begin
        mem_read     <= 1'b0;
        mem_write    <= 1'b0;
        mem_byte_ops <= 1'b0;
        resp_rdata   <= load_data;
      end
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic resp_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_err_q <= 1'b0;
    end else if (accept) begin
      resp_err_q <= misalign;
    end
  end

  assign resp_err = resp_err_q;
`else
  assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench: unit 0 runs with WAIT_CYCLES=1, unit 1 with WAIT_CYCLES=3, each against a byte-array memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic [1:0]  reset;
  logic [1:0]  req_valid, req_ready, req_write, req_byte, req_signed;
  logic [17:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic [1:0]  resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata [2];
  logic [17:0] mem_address [2];
  logic [31:0] mem_write_data [2];
  logic [1:0]  mem_read, mem_write, mem_byte_ops;
  logic [31:0] mem_read_data [2];

  logic [7:0]  mem0 [256];
  logic [7:0]  mem1 [256];
  logic [7:0]  a0, a1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(18), .WAIT_CYCLES(1)) u_lsu_w1 (
    .clk(clk), .reset(reset[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_byte(req_byte[0]), .req_signed(req_signed[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]), .mem_address(mem_address[0]),
    .mem_write_data(mem_write_data[0]), .mem_read(mem_read[0]), .mem_write(mem_write[0]),
    .mem_byte_ops(mem_byte_ops[0]), .mem_read_data(mem_read_data[0])
  );

  load_store_unit #(.ADDR_W(18), .WAIT_CYCLES(3)) u_lsu_w3 (
    .clk(clk), .reset(reset[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_byte(req_byte[1]), .req_signed(req_signed[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]), .mem_address(mem_address[1]),
    .mem_write_data(mem_write_data[1]), .mem_read(mem_read[1]), .mem_write(mem_write[1]),
    .mem_byte_ops(mem_byte_ops[1]), .mem_read_data(mem_read_data[1])
  );

  // Memory model: word at a is {a+3, a+2, a+1, a}; byte stores write only [7:0].
  assign a0 = mem_address[0][7:0];
  assign a1 = mem_address[1][7:0];
  assign mem_read_data[0] = {mem0[a0 + 8'd3], mem0[a0 + 8'd2], mem0[a0 + 8'd1], mem0[a0]};
  assign mem_read_data[1] = {mem1[a1 + 8'd3], mem1[a1 + 8'd2], mem1[a1 + 8'd1], mem1[a1]};

  always @(posedge clk) begin
    if (mem_write[0]) begin
      mem0[a0] <= mem_write_data[0][7:0];
      if (!mem_byte_ops[0]) begin
        mem0[a0 + 8'd1] <= mem_write_data[0][15:8];
        mem0[a0 + 8'd2] <= mem_write_data[0][23:16];
        mem0[a0 + 8'd3] <= mem_write_data[0][31:24];
      end
    end
    if (mem_write[1]) begin
      mem1[a1] <= mem_write_data[1][7:0];
      if (!mem_byte_ops[1]) begin
        mem1[a1 + 8'd1] <= mem_write_data[1][15:8];
        mem1[a1 + 8'd2] <= mem_write_data[1][23:16];
        mem1[a1 + 8'd3] <= mem_write_data[1][31:24];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Issues one request, counts strobe cycles, measures accept-to-resp_valid latency,
  // optionally stalls resp_ready for `hold` cycles, and checks req_ready after the handshake.
  task automatic run_req(input int u, input logic wr, input logic by, input logic sg,
                         input logic [17:0] a, input logic [31:0] wd, input int hold,
                         output logic [31:0] rdata, output logic err, output int lat,
                         output int rd_n, output int wr_n, output logic [17:0] saddr);
    rd_n = 0; wr_n = 0; lat = 0; saddr = '0;
    @(negedge clk);
    req_valid[u] = 1'b1; req_write[u] = wr; req_byte[u] = by; req_signed[u] = sg;
    req_addr[u] = a; req_wdata[u] = wd; resp_ready[u] = (hold == 0);
    check("req_ready_idle", 32'(req_ready[u]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid[u] = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      if (resp_valid[u]) begin
        lat = n;
        break;
      end
      if (mem_read[u]) rd_n++;
      if (mem_write[u]) wr_n++;
      if (mem_read[u] || mem_write[u]) begin
        if (rd_n + wr_n == 1) saddr = mem_address[u];
        else check("addr_stable", 32'(mem_address[u]), 32'(saddr));
      end
      @(negedge clk);
    end
    if (lat == 0) check("resp_timeout", 32'd0, 32'd1);
    check("no_strobe_in_resp", 32'(mem_read[u] | mem_write[u]), 32'd0);
    rdata = resp_rdata[u];
    err   = resp_err[u];
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("resp_held_valid", 32'(resp_valid[u]), 32'd1);
      check("resp_held_data", resp_rdata[u], rdata);
    end
    resp_ready[u] = 1'b1;
    @(negedge clk);
    check("req_ready_after_hs", 32'(req_ready[u]), 32'd1);
    check("resp_valid_after_hs", 32'(resp_valid[u]), 32'd0);
  endtask

  logic [31:0] rdata;
  logic        err;
  int          lat, rd_n, wr_n, seen;
  logic [17:0] saddr;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem0[i] = 8'h00;
      mem1[i] = 8'h00;
    end
    reset = 2'b11;
    req_valid = '0; req_write = '0; req_byte = '0; req_signed = '0; resp_ready = '0;
    req_addr[0] = '0; req_addr[1] = '0; req_wdata[0] = '0; req_wdata[1] = '0;
    repeat (3) @(negedge clk);
    // A request held during reset must be ignored.
    req_valid[0] = 1'b1;
    @(negedge clk);
    check("rst_ignores_req", 32'(mem_read[0]), 32'd0);
    req_valid[0] = 1'b0;
    reset = 2'b00;
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready[0]), 32'd1);
    check("rst_resp_valid", 32'(resp_valid[0]), 32'd0);
    check("rst_resp_err", 32'(resp_err[0]), 32'd0);
    check("rst_resp_rdata", resp_rdata[0], 32'd0);
    check("rst_strobes", 32'({mem_read[0], mem_write[0], mem_byte_ops[0]}), 32'd0);
    check("rst_mem_address", 32'(mem_address[0]), 32'd0);
    check("rst_mem_wdata", mem_write_data[0], 32'd0);

    // sw 0xDEADBEEF @0x10, then lw @0x10 (WAIT_CYCLES=1)
    run_req(0, 1'b1, 1'b0, 1'b0, 18'h10, 32'hDEADBEEF, 0, rdata, err, lat, rd_n, wr_n, saddr);
    check("sw_write_cycles", 32'(wr_n), 32'd1);
    check("sw_read_cycles", 32'(rd_n), 32'd0);
    check("sw_addr", 32'(saddr), 32'h10);
    check("sw_rdata_zero", rdata, 32'd0);
    check("sw_latency", 32'(lat), 32'd2);
    run_req(0, 1'b0, 1'b0, 1'b0, 18'h10, 32'h0, 0, rdata, err, lat, rd_n, wr_n, saddr);
    check("lw_rdata", rdata, 32'hDEADBEEF);
    check("lw_latency", 32'(lat), 32'd2);
    check("lw_read_cycles", 32'(rd_n), 32'd1);
    check("lw_err", 32'(err), 32'd0);

    // Bytes 0x20..0x23 = 80 11 22 33
    run_req(0, 1'b1, 1'b0, 1'b0, 18'h20, 32'h33221180, 0, rdata, err, lat, rd_n, wr_n, saddr);
    run_req(0, 1'b0, 1'b1, 1'b1, 18'h20, 32'h0, 0, rdata, err, lat, rd_n, wr_n, saddr);
    check("lb_neg", rdata, 32'hFFFFFF80);
    run_req(0, 1'b0, 1'b1, 1'b0, 18'h20, 32'h0, 0, rdata, err, lat, rd_n, wr_n, saddr);
    check("lbu", rdata, 32'h00000080);
    run_req(0, 1'b1, 1'b1, 1'b0, 18'h21, 32'hFFFFFF5A, 0, rdata, err, lat, rd_n, wr_n, saddr);
    check("sb_write_cycles", 32'(wr_n), 32'd1);
    run_req(0, 1'b0, 1'b0, 1'b0, 18'h20, 32'h0, 0, rdata, err, lat, rd_n, wr_n, saddr);
    check("lw_after_sb", rdata, 32'h33225A80);
    run_req(0, 1'b0, 1'b1, 1'b1, 18'h21, 32'h0, 0, rdata, err, lat, rd_n, wr_n, saddr);
    check("lb_pos", rdata, 32'h0000005A);

    // Misaligned lw @0x13; memory 0x13..0x16 = DE 00 00 00
    run_req(0, 1'b0, 1'b0, 1'b0, 18'h13, 32'h0, 0, rdata, err, lat, rd_n, wr_n, saddr);
`ifdef LSU_MISALIGN_TRAP_EN
    check("mis_err", 32'(err), 32'd1);
    check("mis_rdata", rdata, 32'd0);
    check("mis_latency", 32'(lat), 32'd1);
    check("mis_no_strobe", 32'(rd_n + wr_n), 32'd0);
`else
    check("mis_err", 32'(err), 32'd0);
    check("mis_read_cycles", 32'(rd_n), 32'd1);
    check("mis_addr", 32'(saddr), 32'h13);
    check("mis_rdata", rdata, 32'h000000DE);
`endif

    // WAIT_CYCLES=3 with response backpressure
    run_req(1, 1'b1, 1'b0, 1'b0, 18'h40, 32'hCAFEF00D, 0, rdata, err, lat, rd_n, wr_n, saddr);
    check("w3_sw_write_cycles", 32'(wr_n), 32'd3);
    check("w3_sw_latency", 32'(lat), 32'd4);
    run_req(1, 1'b0, 1'b0, 1'b0, 18'h40, 32'h0, 4, rdata, err, lat, rd_n, wr_n, saddr);
    check("w3_lw_read_cycles", 32'(rd_n), 32'd3);
    check("w3_lw_latency", 32'(lat), 32'd4);
    check("w3_lw_rdata", rdata, 32'hCAFEF00D);

    // Reset in the 2nd ACCESS cycle of a store
    @(negedge clk);
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_byte[1] = 1'b0;
    req_addr[1] = 18'h80; req_wdata[1] = 32'h12345678; resp_ready[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    check("rstmid_write_1st", 32'(mem_write[1]), 32'd1);
    @(negedge clk);
    check("rstmid_write_2nd", 32'(mem_write[1]), 32'd1);
    reset[1] = 1'b1;
    @(negedge clk);
    check("rstmid_write_drop", 32'(mem_write[1]), 32'd0);
    check("rstmid_resp_valid", 32'(resp_valid[1]), 32'd0);
    reset[1] = 1'b0;
    seen = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (resp_valid[1] || mem_write[1]) seen++;
    end
    check("rstmid_no_resp", 32'(seen), 32'd0);
    check("rstmid_req_ready", 32'(req_ready[1]), 32'd1);

    run_req(1, 1'b0, 1'b0, 1'b0, 18'h40, 32'h0, 0, rdata, err, lat, rd_n, wr_n, saddr);
    check("post_rst_lw", rdata, 32'hCAFEF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the data-memory interface: accepts one load/store request at a time from the processor pipeline and drives the memory's `memRead`/`memWrite`/`byteOperations`/`address`/`write_data` signals. It also captures `read_data` and returns a sign- or zero-extended result through a valid/ready response handshake. It sits between the MEM pipeline stage and `memory_block`. Strobes are held for a fixed number of wait cycles so the memory's level-sensitive write and read logic sees stable inputs.

## Interface
Parameters:
- `ADDR_W`, 18: byte-address width; matches the memory `address` port.
- `WAIT_CYCLES`, 1: cycles the memory strobe is held per access; legal range 1..15.

Ports:
- `clk`  in  1: sole clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: unit can accept a request; high only in IDLE.
- `req_write`  in  1: 1 = store, 0 = load.
- `req_byte`  in  1: 1 = byte access (lb/lbu/sb), 0 = word access.
- `req_signed`  in  1: byte loads only; 1 = sign-extend (lb), 0 = zero-extend (lbu).
- `req_addr`  in  ADDR_W: byte address.
- `req_wdata`  in  32: store data; bits [7:0] are used for sb.
- `resp_valid`  out  1: response present.
- `resp_ready`  in  1: consumer accepts the response.
- `resp_rdata`  out  32: load result; 0 for stores.
- `resp_err`  out  1: misaligned access; see Configuration.
- `mem_address`  out  ADDR_W: to memory `address`.
- `mem_write_data`  out  32: to memory `write_data`.
- `mem_read`  out  1: to `memRead`.
- `mem_write`  out  1: to `memWrite`.
- `mem_byte_ops`  out  1: to `byteOperations`.
- `mem_read_data`  in  32: from memory `read_data`; word at address a is {a+3, a+2, a+1, a}.

## Operation
- FSM states are IDLE, ACCESS and RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid && req_ready`, register addr, wdata, write, byte and signed.
  - Load the wait counter with WAIT_CYCLES-1 and go to ACCESS.
- ACCESS:
  - `mem_read` = !write, `mem_write` = write, `mem_byte_ops` = byte.
  - `mem_address` and `mem_write_data` come from the registered values.
  - Decrement the counter each cycle.
  - On the cycle the counter is 0, capture `mem_read_data` into the response register and go to RESP.
- RESP:
  - `resp_valid`=1.
  - Hold `resp_rdata` and `resp_err` until `resp_valid && resp_ready`, then return to IDLE.
- Load result:
  - Word load: `mem_read_data` unchanged.
  - Byte load: bits [7:0], extended to 32 bits per `req_signed`.
- Store result: `resp_rdata` = 0.
- `mem_read` and `mem_write` are registered outputs and are never high together.
- Both strobes are 0 in IDLE and RESP.
- `mem_address` and `mem_write_data` hold their last value outside ACCESS, so they never change while a strobe is high.
- Requests presented while not in IDLE are ignored; the requester must hold `req_valid` until accepted.

## Timing
- Reset values:
  - State IDLE, so `req_ready`=1 from the first cycle after reset deasserts.
  - `resp_valid`=0, `resp_err`=0, `resp_rdata`=0.
  - `mem_read`=0, `mem_write`=0, `mem_byte_ops`=0.
  - `mem_address`=0, `mem_write_data`=0.
- Requests are ignored while `reset`=1.
- Accept at edge E:
  - Strobes are high in cycles E+1 .. E+WAIT_CYCLES.
  - `resp_valid` rises in cycle E+WAIT_CYCLES+1.
  - With `resp_ready` held high, `req_ready`=1 in cycle E+WAIT_CYCLES+2.
- Minimum issue interval is WAIT_CYCLES+2 cycles.
- Reset during ACCESS or RESP: the strobes and `resp_valid` drop at that edge, the transaction is discarded and no response is produced.

## Configuration
- Macro: `LSU_MISALIGN_TRAP_EN`.
- Defined:
  - A word request with `req_addr[1:0]` != 0 produces no memory strobes.
  - The FSM goes IDLE -> RESP directly; `resp_valid` rises in cycle E+1 with `resp_err`=1 and `resp_rdata`=0.
  - Byte requests are never misaligned.
- Undefined:
  - `resp_err` is tied to 0.
  - Misaligned word addresses are passed to memory unmodified.

## Test plan
- Word store then load: sw 0xDEADBEEF to addr 0x10 with WAIT_CYCLES=1 -> `mem_write` high for exactly 1 cycle with `mem_address`=0x10; a following lw at 0x10 -> `resp_rdata`=0xDEADBEEF, `resp_valid` 2 cycles after accept.
- Byte load with bytes at 0x20..0x23 = 0x80,0x11,0x22,0x33:
  - lb at 0x20 -> `resp_rdata`=0xFFFFFF80.
  - lbu at 0x20 -> `resp_rdata`=0x00000080.
  - sb 0x5A at 0x21, then lw at 0x20 -> 0x33225A80.
- Wait states and backpressure: with WAIT_CYCLES=3 and `resp_ready`=0 for 4 cycles, `mem_read` is high for exactly 3 cycles; `resp_valid` and `resp_rdata` stay stable until `resp_ready`=1; `req_ready` returns the cycle after the handshake.
- Reset mid-access: assert `reset` in the 2nd ACCESS cycle of an sw (WAIT_CYCLES=3) -> `mem_write`=0 at the next edge, no `resp_valid`, `req_ready`=1 after reset.
- Misalignment: lw at 0x13 with `LSU_MISALIGN_TRAP_EN` defined -> no strobes, `resp_err`=1, `resp_rdata`=0 one cycle after accept; without the macro -> `mem_read` high with `mem_address`=0x13 and `resp_err`=0.
